// File: rtl/board_move_engine.sv
// rtl/board_move_engine.sv - N x N 2048 board engine, one line per clock per move
// Optional game-over detection built when GAME_OVER_DETECT_EN is defined.
module board_move_engine #(
   parameter int N       = 4,
   parameter int EW      = 4,
   parameter int SCORE_W = 32,
   parameter int WIN_EXP = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   input  logic [1:0]             cmd_dir,
   output logic                   cmd_ready,
   input  logic                   spawn_valid,
   input  logic [$clog2(N*N)-1:0] spawn_idx,
   input  logic [EW-1:0]          spawn_exp,
   output logic                   spawn_err,
   input  logic                   clear,
   output logic [N*N*EW-1:0]      board,
   output logic [SCORE_W-1:0]     score,
   output logic                   done,
   output logic                   moved,
   output logic                   win,
   output logic                   game_over
);
   localparam int CELLS = N * N;
   localparam int LW    = $clog2(N);
   localparam logic [EW-1:0]    EXP_MAX = '1;
   localparam logic [SCORE_W:0] ONE     = {{SCORE_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [EW-1:0]      cells_q [CELLS];
   logic [EW-1:0]      cells_d [CELLS];
   logic [LW-1:0]      line_q, line_d;
   logic [1:0]         dir_q, dir_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               win_q, win_d;
   logic               done_q, done_d;
   logic               moved_q, moved_d;
   logic               moved_acc_q, moved_acc_d;
   logic               spawn_err_q, spawn_err_d;

   logic [EW-1:0]      line_in  [N];
   logic [EW-1:0]      packed_l [N+1];
   logic [EW-1:0]      line_out [N];
   logic [SCORE_W-1:0] line_score;
   logic               line_win, line_chg;

   // Maps position i (counted from the leading edge) of line k to a cell index.
   function automatic int cell_idx(input logic [1:0] dir, input int k, input int i);
      case (dir)
         2'd0:    cell_idx = k * N + i;
         2'd1:    cell_idx = k * N + (N - 1 - i);
         2'd2:    cell_idx = i * N + k;
         default: cell_idx = (N - 1 - i) * N + k;
      endcase
   endfunction

   always_comb begin
      int   w;
      logic skip;
      logic sat;
      logic [SCORE_W:0] acc;
      for (int i = 0; i < N; i++) line_in[i] = cells_q[cell_idx(dir_q, int'(line_q), i)];
      for (int i = 0; i <= N; i++) packed_l[i] = '0;
      w = 0;
      for (int i = 0; i < N; i++) begin
         if (line_in[i] != '0) begin
            packed_l[w] = line_in[i];
            w = w + 1;
         end
      end
      for (int i = 0; i < N; i++) line_out[i] = '0;
      w        = 0;
      skip     = 1'b0;
      sat      = 1'b0;
      line_win = 1'b0;
      acc      = {1'b0, score_q};
      // packed_l[N] is always zero, so the pair look-ahead never merges past the end.
      for (int i = 0; i < N; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (packed_l[i] != '0) begin
            if (packed_l[i] == packed_l[i+1] && packed_l[i] != EXP_MAX) begin
               line_out[w] = packed_l[i] + 1'b1;
               skip        = 1'b1;
               if (int'(packed_l[i]) + 1 >= WIN_EXP) line_win = 1'b1;
               if (int'(packed_l[i]) + 1 >= SCORE_W) begin
                  sat = 1'b1;
               end else begin
                  acc = acc + (ONE << (packed_l[i] + 1'b1));
                  if (acc[SCORE_W]) begin
                     sat          = 1'b1;
                     acc[SCORE_W] = 1'b0;
                  end
               end
            end else begin
               line_out[w] = packed_l[i];
            end
            w = w + 1;
         end
      end
      line_score = sat ? '1 : acc[SCORE_W-1:0];
      line_chg   = 1'b0;
      for (int i = 0; i < N; i++) if (line_out[i] != line_in[i]) line_chg = 1'b1;
   end

`ifdef GAME_OVER_DETECT_EN
   logic game_over_q, game_over_d;
   logic board_stuck;

   always_comb begin
      board_stuck = 1'b1;
      for (int i = 0; i < CELLS; i++) if (cells_q[i] == '0) board_stuck = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N - 1; c++)
            if (cells_q[r*N+c] == cells_q[r*N+c+1]) board_stuck = 1'b0;
      for (int r = 0; r < N - 1; r++)
         for (int c = 0; c < N; c++)
            if (cells_q[r*N+c] == cells_q[(r+1)*N+c]) board_stuck = 1'b0;
   end
`endif

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      dir_d       = dir_q;
      score_d     = score_q;
      cells_d     = cells_q;
      win_d       = win_q;
      done_d      = 1'b0;
      moved_d     = 1'b0;
      moved_acc_d = moved_acc_q;
      spawn_err_d = 1'b0;
`ifdef GAME_OVER_DETECT_EN
      game_over_d = game_over_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef GAME_OVER_DETECT_EN
            game_over_d = board_stuck && !clear;
`endif
            if (clear) begin
               for (int i = 0; i < CELLS; i++) cells_d[i] = '0;
               score_d = '0;
               win_d   = 1'b0;
            end else if (cmd_valid) begin
               state_d     = S_LINE;
               line_d      = '0;
               dir_d       = cmd_dir;
               moved_acc_d = 1'b0;
               spawn_err_d = spawn_valid;
            end else if (spawn_valid) begin
               if (int'(spawn_idx) < CELLS && cells_q[spawn_idx] == '0 && spawn_exp != '0)
                  cells_d[spawn_idx] = spawn_exp;
               else
                  spawn_err_d = 1'b1;
            end
         end
         S_LINE: begin
            for (int i = 0; i < N; i++) cells_d[cell_idx(dir_q, int'(line_q), i)] = line_out[i];
            score_d     = line_score;
            win_d       = win_q | line_win;
            moved_acc_d = moved_acc_q | line_chg;
            spawn_err_d = spawn_valid;
            if (line_q == LW'(N - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               moved_d = moved_acc_q | line_chg;
            end else begin
               line_d = line_q + 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            spawn_err_d = spawn_valid;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         line_q      <= '0;
         dir_q       <= '0;
         score_q     <= '0;
         for (int i = 0; i < CELLS; i++) cells_q[i] <= '0;
         win_q       <= 1'b0;
         done_q      <= 1'b0;
         moved_q     <= 1'b0;
         moved_acc_q <= 1'b0;
         spawn_err_q <= 1'b0;
`ifdef GAME_OVER_DETECT_EN
         game_over_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         dir_q       <= dir_d;
         score_q     <= score_d;
         cells_q     <= cells_d;
         win_q       <= win_d;
         done_q      <= done_d;
         moved_q     <= moved_d;
         moved_acc_q <= moved_acc_d;
         spawn_err_q <= spawn_err_d;
`ifdef GAME_OVER_DETECT_EN
         game_over_q <= game_over_d;
`endif
      end
   end

   for (genvar g = 0; g < CELLS; g++) begin : g_board
      assign board[g*EW +: EW] = cells_q[g];
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign spawn_err = spawn_err_q;
   assign score     = score_q;
   assign done      = done_q;
   assign moved     = moved_q;
   assign win       = win_q;
`ifdef GAME_OVER_DETECT_EN
   assign game_over = game_over_q;
`else
   assign game_over = 1'b0;
`endif
endmodule

// File: tb/tb_board_move_engine.sv
// tb/tb_board_move_engine.sv - self-checking bench for board_move_engine
// Transaction-level board model drives per-cycle expectations; literals pin the model.
module tb_board_move_engine;
   localparam int N     = 4;
   localparam int EW    = 4;
   localparam int CELLS = N * N;
   localparam longint SMAX = (longint'(1) << 32) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic [1:0]    cmd_dir;
   logic          cmd_ready;
   logic          spawn_valid;
   logic [3:0]    spawn_idx;
   logic [3:0]    spawn_exp;
   logic          spawn_err;
   logic          clear;
   logic [63:0]   board;
   logic [31:0]   score;
   logic          done, moved, win, game_over;

   board_move_engine #(.N(N), .EW(EW), .SCORE_W(32), .WIN_EXP(11)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
      .spawn_valid(spawn_valid), .spawn_idx(spawn_idx), .spawn_exp(spawn_exp), .spawn_err(spawn_err),
      .clear(clear), .board(board), .score(score), .done(done), .moved(moved), .win(win),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     failures = 0;
   bit     chk_en = 0;
   int     eb [CELLS];
   longint escore;
   bit     ewin, edone, emoved, eready, eserr, egover;
   int     mv_nb [CELLS];
   longint mv_gain [N];
   bit     mv_win [N];
   bit     mv_chg;
   bit     last_done, last_moved;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < CELLS; c++) chk($sformatf("cell%0d", c), board[c*EW +: EW], eb[c]);
         chk("score", score, escore);
         chk("done", done, edone);
         if (edone) chk("moved", moved, emoved);
         chk("cmd_ready", cmd_ready, eready);
         chk("spawn_err", spawn_err, eserr);
         chk("win", win, ewin);
         chk("game_over", game_over, egover);
      end
   end

   function automatic int lpos(input int dir, input int k, input int i);
      case (dir)
         0: return k * N + i;
         1: return k * N + N - 1 - i;
         2: return i * N + k;
         default: return (N - 1 - i) * N + k;
      endcase
   endfunction

   function automatic bit model_stuck();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (eb[r*N+c] == 0) return 0;
            if (c < N - 1) if (eb[r*N+c] == eb[r*N+c+1]) return 0;
            if (r < N - 1) if (eb[r*N+c] == eb[(r+1)*N+c]) return 0;
         end
      return 1;
   endfunction

   function automatic bit go_next();
`ifdef GAME_OVER_DETECT_EN
      return model_stuck();
`else
      return 0;
`endif
   endfunction

   // Slide then merge each line with queues, in leading-edge order.
   task automatic model_move(input int dir);
      int q[$];
      int r[$];
      int j;
      mv_chg = 0;
      for (int k = 0; k < N; k++) begin
         q.delete();
         r.delete();
         mv_gain[k] = 0;
         mv_win[k]  = 0;
         for (int i = 0; i < N; i++) if (eb[lpos(dir, k, i)] != 0) q.push_back(eb[lpos(dir, k, i)]);
         j = 0;
         while (j < q.size()) begin
            if (j + 1 < q.size() && q[j] == q[j+1] && q[j] != 15) begin
               r.push_back(q[j] + 1);
               mv_gain[k] += longint'(1) << (q[j] + 1);
               if (q[j] + 1 >= 11) mv_win[k] = 1;
               j += 2;
            end else begin
               r.push_back(q[j]);
               j += 1;
            end
         end
         while (r.size() < N) r.push_back(0);
         for (int i = 0; i < N; i++) begin
            mv_nb[lpos(dir, k, i)] = r[i];
            if (r[i] != eb[lpos(dir, k, i)]) mv_chg = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit g;
      repeat (n) begin
         g = go_next();
         tick();
         egover = g;
         eserr  = 0;
      end
   endtask

   task automatic spawn(input int idx, input int e);
      bit g, ok;
      g  = go_next();
      ok = (eb[idx] == 0 && e != 0);
      spawn_valid = 1;
      spawn_idx   = 4'(idx);
      spawn_exp   = 4'(e);
      tick();
      spawn_valid = 0;
      egover = g;
      eserr  = !ok;
      if (ok) eb[idx] = e;
   endtask

   task automatic clear_game();
      clear = 1;
      tick();
      clear = 0;
      for (int i = 0; i < CELLS; i++) eb[i] = 0;
      escore = 0; ewin = 0; egover = 0; eserr = 0;
   endtask

   task automatic do_move(input int dir, input bit busy_poke, input bit cmd_spawn);
      bit g;
      model_move(dir);
      g = go_next();
      cmd_valid   = 1;
      cmd_dir     = 2'(dir);
      spawn_valid = cmd_spawn;
      spawn_idx   = 4'd15;
      spawn_exp   = 4'd1;
      tick();
      egover = g;
      eready = 0;
      eserr  = cmd_spawn;
      cmd_valid   = busy_poke;
      clear       = busy_poke;
      spawn_valid = busy_poke;
      for (int k = 0; k < N; k++) begin
         tick();
         for (int i = 0; i < N; i++) eb[lpos(dir, k, i)] = mv_nb[lpos(dir, k, i)];
         escore += mv_gain[k];
         if (escore > SMAX) escore = SMAX;
         ewin  = ewin | mv_win[k];
         eserr = busy_poke;
         if (k == N - 1) begin
            edone  = 1;
            emoved = mv_chg;
         end
      end
      @(negedge clk);
      last_done  = done;
      last_moved = moved;
      tick();
      cmd_valid = 0; clear = 0; spawn_valid = 0;
      edone = 0; emoved = 0; eready = 1; eserr = busy_poke;
      idle(1);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst_n = 0; cmd_valid = 0; cmd_dir = 0; spawn_valid = 0; spawn_idx = 0; spawn_exp = 0; clear = 0;
      for (int i = 0; i < CELLS; i++) eb[i] = 0;
      escore = 0; ewin = 0; edone = 0; emoved = 0; eready = 1; eserr = 0; egover = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk_en = 1;
      idle(2);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_score", score, 0);
      chk("rst_board", (board == 64'd0), 1);

      // [1,1,1,1] left -> [2,2,0,0], +8
      for (int c = 0; c < 4; c++) spawn(c, 1);
      idle(1);
      do_move(0, 0, 0);
      chk("t1_row0", board[15:0], 16'h0022);
      chk("t1_score", score, 8);
      chk("t1_done_lat", last_done, 1);
      chk("t1_moved", last_moved, 1);

      // [1,1,2,0] right -> [0,0,2,2], +4
      clear_game();
      spawn(0, 1); spawn(1, 1); spawn(2, 2);
      do_move(1, 0, 0);
      chk("t2_row0", board[15:0], 16'h2200);
      chk("t2_score", score, 4);

      // [1,2,3,4] left -> unchanged
      clear_game();
      spawn(0, 1); spawn(1, 2); spawn(2, 3); spawn(3, 4);
      do_move(0, 0, 0);
      chk("t3_row0", board[15:0], 16'h4321);
      chk("t3_moved", last_moved, 0);
      chk("t3_done", last_done, 1);
      chk("t3_score", score, 0);

      // spawn rejects: occupied, zero exponent; then a good one
      spawn(1, 1);
      chk("t4_err_occ", spawn_err, 1);
      spawn(5, 0);
      chk("t4_err_zero", spawn_err, 1);
      spawn(5, 1);
      chk("t4_ok", spawn_err, 0);
      chk("t4_cell5", board[23:20], 1);
      idle(1);

      // two 10s up column 0 -> 11, win sticky
      clear_game();
      spawn(0, 10); spawn(4, 10);
      do_move(2, 0, 0);
      chk("t5_cell0", board[3:0], 11);
      chk("t5_score", score, 2048);
      chk("t5_win", win, 1);
      do_move(3, 0, 0);
      chk("t5_cell12", board[51:48], 11);
      chk("t5_win_sticky", win, 1);
      clear_game();
      idle(1);
      chk("t5_win_clr", win, 0);

      // saturated exponents never merge
      spawn(0, 15); spawn(1, 15);
      do_move(1, 0, 0);
      chk("t6_row0", board[15:0], 16'hFF00);
      chk("t6_score", score, 0);

      // busy poke: cmd/clear/spawn held while busy, spawn beside an accepted cmd
      clear_game();
      spawn(0, 2); spawn(2, 2);
      do_move(0, 1, 1);
      chk("t7_row0", board[15:0], 16'h0003);
      chk("t7_score", score, 8);

      // clear beats cmd and spawn in the same cycle
      cmd_valid = 1; cmd_dir = 0; clear = 1; spawn_valid = 1; spawn_idx = 7; spawn_exp = 1;
      tick();
      cmd_valid = 0; clear = 0; spawn_valid = 0;
      for (int i = 0; i < CELLS; i++) eb[i] = 0;
      escore = 0; ewin = 0; egover = 0; eserr = 0;
      idle(1);
      chk("t8_ready", cmd_ready, 1);
      chk("t8_score", score, 0);

      // checkerboard of 1/2
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) spawn(r*N+c, ((r + c) % 2) ? 2 : 1);
      idle(2);
`ifdef GAME_OVER_DETECT_EN
      chk("t9_game_over", game_over, 1);
`else
      chk("t9_game_over", game_over, 0);
`endif
      do_move(0, 0, 0);
      chk("t9_moved", last_moved, 0);

      // reset mid-move discards everything
      clear_game();
      spawn(0, 3); spawn(4, 3);
      idle(1);
      chk_en = 0;
      cmd_valid = 1; cmd_dir = 3;
      tick();
      cmd_valid = 0;
      tick();
      tick();
      rst_n = 0;
      @(negedge clk);
      chk("t10_board", (board == 64'd0), 1);
      chk("t10_score", score, 0);
      chk("t10_done", done, 0);
      tick();
      rst_n = 1;
      for (int i = 0; i < CELLS; i++) eb[i] = 0;
      escore = 0; ewin = 0; edone = 0; emoved = 0; eready = 1; eserr = 0; egover = 0;
      @(negedge clk);
      chk("t10_ready", cmd_ready, 1);
      tick();
      chk_en = 1;
      spawn(5, 1);
      do_move(0, 0, 0);
      chk("t10_cell4", board[19:16], 1);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
